// File: rtl/ev_cnt_pkg.sv
// ---------------------------------------------------------------------------
// ev_cnt_pkg
// Shared constants and helpers for the multi-channel event counter bank.
//   EDGE_*      : 2-bit per-channel edge-mode encodings
//   SYNC_STAGES : depth of the per-channel input synchroniser
//   ARM_CYCLES  : clocks after reset release before edges are honoured
//   edge_match  : decides whether a detected edge qualifies under a mode
// ---------------------------------------------------------------------------
package ev_cnt_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    localparam int SYNC_STAGES = 2;
    localparam int ARM_CYCLES  = 3;

    // Map a (rise, fall) pair onto the selected edge mode.
    function automatic logic edge_match(input logic [1:0] mode,
                                        input logic       rise,
                                        input logic       fall);
        logic hit;
        case (mode)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            EDGE_BOTH: hit = rise | fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ev_cnt_chan.sv
// ---------------------------------------------------------------------------
// ev_cnt_chan
// One event-counter channel: synchroniser, optional debounce filter, history
// flop, edge qualification, wrap/saturate counter with sticky overflow,
// synchronous clear and snapshot register.
// Optional feature macro: EV_CNT_DEBOUNCE_EN (inserts the debounce filter).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ev         : raw asynchronous event line
//   en         : count enable
//   mode       : edge mode (OFF/RISE/FALL/BOTH)
//   clr        : clears counter and overflow flag on the next clock
//   snap       : loads the counter into the snapshot register
//   armed      : bank-wide qualifier, low during the post-reset settle time
//   cnt        : live counter value
//   snap_val   : snapshot register value
//   ovf        : sticky overflow flag
// ---------------------------------------------------------------------------
module ev_cnt_chan
    import ev_cnt_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int SATURATE  = 0,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ev,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic             snap,
    input  logic             armed,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] snap_val,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   filt;
    logic                   hist_q;
    logic                   hit_q;
    logic                   rise;
    logic                   fall;

    // Two-flop synchroniser for the asynchronous event line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ev};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef EV_CNT_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CYCLES + 1);

    logic [DB_W-1:0] db_cnt;

    // The filtered level only follows the synced level after the two have
    // disagreed for DB_CYCLES consecutive clocks; any return to agreement
    // restarts the window, so short glitches never reach the edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            filt   <= 1'b0;
        end else if (synced == filt) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
            db_cnt <= '0;
            filt   <= synced;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    assign filt = synced;
`endif

    assign rise = filt & ~hist_q;
    assign fall = ~filt & hist_q;

    // History always follows the filtered level, independent of mode and
    // enable, so turning a channel on never manufactures an edge. The
    // qualified edge is registered before it reaches the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 1'b0;
            hit_q  <= 1'b0;
        end else begin
            hist_q <= filt;
            hit_q  <= armed & en & edge_match(mode, rise, fall);
        end
    end

    // Counter with wrap or saturate; clear takes priority and drops any
    // increment landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (hit_q) begin
            if (cnt == CNT_MAX) begin
                ovf <= 1'b1;
                cnt <= (SATURATE != 0) ? CNT_MAX : '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Snapshot samples the register value, i.e. before any same-edge
    // increment or clear takes effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_val <= '0;
        end else if (snap) begin
            snap_val <= cnt;
        end
    end

endmodule

// File: rtl/ev_counter_bank.sv
// ---------------------------------------------------------------------------
// ev_counter_bank
// Bank of CH_NUM event counters with a shared post-reset arming delay, a
// bank-wide snapshot strobe and a channel-select read mux.
// Optional feature macro: EV_CNT_DEBOUNCE_EN (per-channel debounce filter of
// DB_CYCLES clocks; DB_CYCLES is otherwise unused).
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   ev_i          : raw asynchronous event lines, bit n = channel n
//   en_i          : per-channel count enable
//   mode_i        : per-channel edge mode, bits [2n+1:2n]
//   clr_i         : per-channel synchronous clear (counter + overflow)
//   snap_i        : capture every live counter into its snapshot register
//   sel_i         : channel select for the read outputs
//   cnt_o         : live count of the selected channel (0 if out of range)
//   snap_o        : snapshot of the selected channel (0 if out of range)
//   ovf_o         : sticky overflow flags
// ---------------------------------------------------------------------------
module ev_counter_bank
    import ev_cnt_pkg::*;
#(
    parameter int CH_NUM    = 4,
    parameter int CNT_W     = 32,
    parameter int SATURATE  = 0,
    parameter int DB_CYCLES = 16
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic [CH_NUM-1:0]                            ev_i,
    input  logic [CH_NUM-1:0]                            en_i,
    input  logic [2*CH_NUM-1:0]                          mode_i,
    input  logic [CH_NUM-1:0]                            clr_i,
    input  logic                                         snap_i,
    input  logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] sel_i,
    output logic [CNT_W-1:0]                             cnt_o,
    output logic [CNT_W-1:0]                             snap_o,
    output logic [CH_NUM-1:0]                            ovf_o
);

    // Reject unsupported configurations at elaboration time.
    if (CH_NUM < 1 || CH_NUM > 16 || CNT_W < 8 || CNT_W > 32 || DB_CYCLES < 2) begin : g_bad_cfg
        $error("ev_counter_bank: unsupported parameter combination");
    end

    logic [1:0]       arm_cnt;
    logic             armed;
    logic [CNT_W-1:0] cnt_arr  [CH_NUM];
    logic [CNT_W-1:0] snap_arr [CH_NUM];

    // Shared arm counter: edges seen while the synchronisers are still
    // filling after reset release are discarded, so a line held high
    // through reset does not count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arm_cnt <= '0;
        end else if (arm_cnt != 2'(ARM_CYCLES)) begin
            arm_cnt <= arm_cnt + 1'b1;
        end
    end

    assign armed = (arm_cnt == 2'(ARM_CYCLES));

    for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
        ev_cnt_chan #(
            .CNT_W     (CNT_W),
            .SATURATE  (SATURATE),
            .DB_CYCLES (DB_CYCLES)
        ) u_chan (
            .clk      (clk_i),
            .rst_n    (rst_ni),
            .ev       (ev_i[g]),
            .en       (en_i[g]),
            .mode     (mode_i[2*g +: 2]),
            .clr      (clr_i[g]),
            .snap     (snap_i),
            .armed    (armed),
            .cnt      (cnt_arr[g]),
            .snap_val (snap_arr[g]),
            .ovf      (ovf_o[g])
        );
    end

    // Read mux; a select beyond the last channel reads as zero.
    always_comb begin
        cnt_o  = '0;
        snap_o = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (int'(sel_i) == i) begin
                cnt_o  = cnt_arr[i];
                snap_o = snap_arr[i];
            end
        end
    end

endmodule

// File: tb/tb_ev_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_ev_counter_bank
// Self-checking bench for ev_counter_bank. Two instances share all inputs:
// one wraps on overflow, one saturates. Three channels leave select value 3
// out of range. Expected values come from an event-level model: every driven
// level change is classified against the current mode/enable and counted.
// Honours EV_CNT_DEBOUNCE_EN for latency and the glitch-rejection steps.
// ---------------------------------------------------------------------------
module tb_ev_counter_bank;

    localparam int CH   = 3;
    localparam int W    = 8;
    localparam int DB   = 16;
    localparam int MAXV = 255;
`ifdef EV_CNT_DEBOUNCE_EN
    localparam int LAT = DB + 3;
`else
    localparam int LAT = 3;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   ev;
    logic [CH-1:0]   en;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   clr;
    logic            snap;
    logic [1:0]      sel;
    logic [W-1:0]    cnt_w, snap_w, cnt_s, snap_s;
    logic [CH-1:0]   ovf_w, ovf_s;

    int n_cmp = 0;
    int n_err = 0;

    int lvl       [CH];
    int exp_cnt   [CH];
    int exp_ovf   [CH];
    int exp_snap  [CH];
    int exp_cnt_s [CH];
    int exp_ovf_s [CH];
    int exp_snap_s[CH];

    always #5 clk = ~clk;

    ev_counter_bank #(.CH_NUM(CH), .CNT_W(W), .SATURATE(0), .DB_CYCLES(DB)) dut_wrap (
        .clk_i(clk), .rst_ni(rst_n), .ev_i(ev), .en_i(en), .mode_i(mode),
        .clr_i(clr), .snap_i(snap), .sel_i(sel),
        .cnt_o(cnt_w), .snap_o(snap_w), .ovf_o(ovf_w)
    );

    ev_counter_bank #(.CH_NUM(CH), .CNT_W(W), .SATURATE(1), .DB_CYCLES(DB)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .ev_i(ev), .en_i(en), .mode_i(mode),
        .clr_i(clr), .snap_i(snap), .sel_i(sel),
        .cnt_o(cnt_s), .snap_o(snap_s), .ovf_o(ovf_s)
    );

    // Hard time limit so the run always ends.
    initial begin
        #20_000_000;
        $display("[TB] FAIL watchdog: observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Compare all read outputs of both instances for one channel.
    task automatic check_chan(input string tag, input int ch);
        sel = 2'(ch);
        #1;
        check_output({tag, "_cnt_wrap"},  32'(cnt_w),     32'(exp_cnt[ch]));
        check_output({tag, "_snap_wrap"}, 32'(snap_w),    32'(exp_snap[ch]));
        check_output({tag, "_ovf_wrap"},  32'(ovf_w[ch]), 32'(exp_ovf[ch]));
        check_output({tag, "_cnt_sat"},   32'(cnt_s),     32'(exp_cnt_s[ch]));
        check_output({tag, "_snap_sat"},  32'(snap_s),    32'(exp_snap_s[ch]));
        check_output({tag, "_ovf_sat"},   32'(ovf_s[ch]), 32'(exp_ovf_s[ch]));
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < CH; c++) check_chan(tag, c);
    endtask

    // Reference model: classify a level change on a channel and count it.
    task automatic model_edge(input int ch, input int v);
        logic [1:0] m;
        bit rise, hit;
        if (v == lvl[ch]) return;
        rise    = (v == 1);
        lvl[ch] = v;
        m       = mode[2*ch +: 2];
        hit     = en[ch] && ((m == 2'b11) || (m == 2'b01 && rise) || (m == 2'b10 && !rise));
        if (hit) begin
            if (exp_cnt[ch] == MAXV) begin
                exp_cnt[ch] = 0;
                exp_ovf[ch] = 1;
            end else begin
                exp_cnt[ch]++;
            end
            if (exp_cnt_s[ch] == MAXV) exp_ovf_s[ch] = 1;
            else                       exp_cnt_s[ch]++;
        end
    endtask

    task automatic apply_stimulus(input int ch, input int v);
        ev[ch] = v[0];
        model_edge(ch, v);
    endtask

    task automatic settle();
        tick(LAT + 1);
    endtask

    // Drive a level change and confirm the count moves on exactly the
    // expected clock, not one earlier.
    task automatic transition_checked(input string tag, input int ch, input int v);
        int pre_w, pre_s;
        pre_w = exp_cnt[ch];
        pre_s = exp_cnt_s[ch];
        apply_stimulus(ch, v);
        tick(LAT);
        sel = 2'(ch);
        #1;
        check_output({tag, "_early_wrap"}, 32'(cnt_w), 32'(pre_w));
        check_output({tag, "_early_sat"},  32'(cnt_s), 32'(pre_s));
        tick(1);
        #1;
        check_output({tag, "_ontime_wrap"}, 32'(cnt_w), 32'(exp_cnt[ch]));
        check_output({tag, "_ontime_sat"},  32'(cnt_s), 32'(exp_cnt_s[ch]));
    endtask

    task automatic pulse_clr(input int ch);
        clr[ch] = 1'b1;
        tick(1);
        clr[ch] = 1'b0;
        exp_cnt[ch]   = 0;
        exp_ovf[ch]   = 0;
        exp_cnt_s[ch] = 0;
        exp_ovf_s[ch] = 0;
    endtask

    task automatic pulse_snap();
        snap = 1'b1;
        tick(1);
        snap = 1'b0;
        for (int c = 0; c < CH; c++) begin
            exp_snap[c]   = exp_cnt[c];
            exp_snap_s[c] = exp_cnt_s[c];
        end
    endtask

    initial begin
        int pre;
        int r, ch;

        for (int c = 0; c < CH; c++) begin
            lvl[c] = 0; exp_cnt[c] = 0; exp_ovf[c] = 0; exp_snap[c] = 0;
            exp_cnt_s[c] = 0; exp_ovf_s[c] = 0; exp_snap_s[c] = 0;
        end

        // Reset with channel 0 held high, all channels RISE and enabled.
        rst_n = 1'b0;
        ev    = 3'b001;
        en    = 3'b111;
        mode  = 6'b01_01_01;
        clr   = '0;
        snap  = 1'b0;
        sel   = 2'd0;
        lvl[0] = 1;
        tick(3);
        check_chan("in_reset", 0);
        rst_n = 1'b1;
        tick(10);
        check_all("held_high");
`ifdef EV_CNT_DEBOUNCE_EN
        // The filtered level starts at 0, so the held line appears as a
        // rise once the debounce window completes after arming.
        tick(DB + 5);
        lvl[0] = 0;
        model_edge(0, 1);
        check_chan("held_high_db", 0);
`endif

        // Channel 1 in BOTH mode: five pulses give ten counts.
        mode[3:2] = 2'b11;
        for (int p = 0; p < 5; p++) begin
            transition_checked("both_rise", 1, 1);
            transition_checked("both_fall", 1, 0);
        end
        sel = 2'd1;
        #1;
        check_output("both_total", 32'(cnt_w), 32'd10);
        check_chan("both", 1);

        // FALL mode: enable toggling while high must not count.
        mode[3:2] = 2'b10;
        pre = exp_cnt[1];
        transition_checked("fall_rise", 1, 1);
        for (int k = 0; k < 3; k++) begin
            en[1] = 1'b0; tick(2);
            en[1] = 1'b1; tick(2);
        end
        settle();
        check_chan("en_toggle", 1);
        transition_checked("fall_drop", 1, 0);
        sel = 2'd1;
        #1;
        check_output("fall_one", 32'(cnt_w), 32'(pre + 1));

        // Channel 2 overflow: 255 rises reach all-ones, the 256th wraps or holds.
        pulse_clr(2);
        for (int p = 0; p < 255; p++) begin
            apply_stimulus(2, 1); settle();
            apply_stimulus(2, 0); settle();
        end
        check_chan("at_max", 2);
        apply_stimulus(2, 1); settle();
        apply_stimulus(2, 0); settle();
        check_chan("overflow", 2);
        sel = 2'd2;
        #1;
        check_output("wrap_zero", 32'(cnt_w), 32'd0);
        check_output("sat_max",   32'(cnt_s), 32'd255);

        // Channel 0 at 7: clear and snapshot on the same edge as an increment.
        pulse_clr(0);
        apply_stimulus(0, 0); settle();
        for (int p = 0; p < 7; p++) begin
            apply_stimulus(0, 1); settle();
            apply_stimulus(0, 0); settle();
        end
        check_chan("seven", 0);
        ev[0]  = 1'b1;
        lvl[0] = 1;
        tick(LAT);
        clr[0] = 1'b1;
        snap   = 1'b1;
        tick(1);
        clr[0] = 1'b0;
        snap   = 1'b0;
        for (int c = 0; c < CH; c++) begin
            exp_snap[c]   = exp_cnt[c];
            exp_snap_s[c] = exp_cnt_s[c];
        end
        exp_cnt[0] = 0; exp_ovf[0] = 0; exp_cnt_s[0] = 0; exp_ovf_s[0] = 0;
        sel = 2'd0;
        #1;
        check_output("clrsnap_cnt",  32'(cnt_w),    32'd0);
        check_output("clrsnap_snap", 32'(snap_w),   32'd7);
        check_output("clrsnap_ovf",  32'(ovf_w[0]), 32'd0);
        settle();
        check_all("after_clrsnap");
        apply_stimulus(0, 0); settle();

        // Out-of-range select reads zero.
        sel = 2'd3;
        #1;
        check_output("sel_oor_cnt",  32'(cnt_w),  32'd0);
        check_output("sel_oor_snap", 32'(snap_w), 32'd0);
        check_output("sel_oor_sat",  32'(snap_s), 32'd0);

        // Randomised mix of edges, mode/enable changes, clears and snapshots.
        for (int it = 0; it < 60; it++) begin
            r  = int'($urandom_range(0, 5));
            ch = int'($urandom_range(0, CH - 1));
            case (r)
                0, 1, 2: begin apply_stimulus(ch, 1 - lvl[ch]); settle(); end
                3:       begin mode[2*ch +: 2] = 2'($urandom_range(0, 3)); tick(2); end
                4:       begin en[ch] = 1'($urandom_range(0, 1)); tick(2); end
                default: begin
                    if ($urandom_range(0, 1) == 1) pulse_snap();
                    else                          pulse_clr(ch);
                    tick(1);
                end
            endcase
            check_chan("rand", int'($urandom_range(0, CH - 1)));
        end
        check_all("rand_end");

`ifdef EV_CNT_DEBOUNCE_EN
        // Short glitch rejected; a long pulse counts once after DB+3 clocks.
        mode[3:2] = 2'b01;
        en[1]     = 1'b1;
        if (lvl[1] == 1) begin apply_stimulus(1, 0); settle(); end
        ev[1] = 1'b1;
        tick(10);
        ev[1] = 1'b0;
        tick(DB + 10);
        check_chan("glitch", 1);
        transition_checked("db_rise", 1, 1);
        apply_stimulus(1, 0); settle();
        check_chan("db_pulse", 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
